// File: rtl/control_unit.sv
// Instruction sequencing stage: decodes the presented instruction into program-counter
// controls, owns the return-address stack and halt state, and forwards accepted work to execute.
module control_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4,
    localparam int SP_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [15:0]           i_instruction,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_flag_zero,
    input  logic                  i_flag_carry,
    input  logic                  i_mem_ready,
    output logic                  o_pc_inc,
    output logic                  o_pc_load,
    output logic [ADDR_WIDTH-1:0] o_pc_addr,
    output logic                  o_mem_req,
    output logic                  o_exec_valid,
    output logic [15:0]           o_exec_instr,
    output logic                  o_halted,
    output logic                  o_stack_error,
    output logic [1:0]            o_dbg_state,
    output logic [SP_WIDTH-1:0]   o_dbg_sp
);
    localparam int IDX_WIDTH = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [SP_WIDTH-1:0]   sp;
    logic                  prev_adv;
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [3:0]            opcode;
    logic [1:0]            cond;
    logic [ADDR_WIDTH-1:0] target;
    logic                  is_halt, is_nop, jmp_taken;
    logic                  stack_full, stack_empty;
    logic [ADDR_WIDTH-1:0] fetch_addr, ret_addr;
    logic [IDX_WIDTH-1:0]  push_idx, top_idx;

    logic                  pc_inc, pc_load, mem_req;
    logic [ADDR_WIDTH-1:0] pc_addr;
    logic                  push, pop, stack_err_set, accept;

    assign opcode      = i_instruction[15:12];
    assign cond        = i_instruction[11:10];
    assign target      = i_instruction[ADDR_WIDTH-1:0];
    assign is_halt     = (i_instruction == 16'hF000);
    assign is_nop      = (opcode == 4'hF) && !is_halt;
    assign stack_full  = (sp == SP_WIDTH'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign push_idx    = IDX_WIDTH'(sp);
    assign top_idx     = IDX_WIDTH'(sp - 1'b1);

    // After an advance the PC already points one past the instruction it is presenting.
    assign fetch_addr = prev_adv ? (i_pc - ADDR_WIDTH'(1)) : i_pc;
    assign ret_addr   = fetch_addr + ADDR_WIDTH'(1);

    always_comb begin
        jmp_taken = 1'b0;
        case (cond)
            2'b00: jmp_taken = 1'b1;
            2'b01: jmp_taken = i_flag_zero;
            2'b10: jmp_taken = !i_flag_zero;
            2'b11: jmp_taken = i_flag_carry;
        endcase
    end

    always_comb begin
        state_next    = state;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        pc_addr       = '0;
        mem_req       = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        stack_err_set = 1'b0;
        accept        = 1'b0;
        case (state)
            S_BOOT: begin
                pc_load    = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                accept = !is_nop;
                if (is_nop) begin
                    pc_inc = 1'b1;
                end else begin
                    case (opcode)
                        4'h8: begin
                            if (jmp_taken) begin
                                pc_load = 1'b1;
                                pc_addr = target;
                            end else begin
                                pc_inc = 1'b1;
                            end
                        end
                        4'h9: begin
                            if (stack_full) begin
                                stack_err_set = 1'b1;
                                state_next    = S_HALT;
                            end else begin
                                push    = 1'b1;
                                pc_load = 1'b1;
                                pc_addr = target;
                            end
                        end
                        4'hC: begin
                            if (stack_empty) begin
                                stack_err_set = 1'b1;
                                state_next    = S_HALT;
                            end else begin
                                pop     = 1'b1;
                                pc_load = 1'b1;
                                pc_addr = stack_mem[top_idx];
                            end
                        end
                        4'hA, 4'hB: begin
                            mem_req    = 1'b1;
                            state_next = S_MEM_WAIT;
                        end
                        4'hF: state_next = S_HALT;
                        default: pc_inc = 1'b1;
                    endcase
                end
            end
            S_MEM_WAIT: begin
                if (i_mem_ready) state_next = S_RUN;
                else             mem_req    = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_pc_inc    = pc_inc;
    assign o_pc_load   = pc_load;
    assign o_pc_addr   = pc_addr;
    assign o_mem_req   = mem_req && !i_reset;
    assign o_halted    = (state == S_HALT);
    assign o_dbg_state = state;
    assign o_dbg_sp    = sp;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_BOOT;
            sp            <= '0;
            prev_adv      <= 1'b0;
            o_exec_valid  <= 1'b0;
            o_exec_instr  <= 16'hFFFF;
            o_stack_error <= 1'b0;
        end else begin
            state        <= state_next;
            prev_adv     <= pc_inc && !pc_load;
            o_exec_valid <= accept;
            if (accept)        o_exec_instr  <= i_instruction;
            if (push)          sp            <= sp + 1'b1;
            else if (pop)      sp            <= sp - 1'b1;
            if (stack_err_set) o_stack_error <= 1'b1;
        end
    end

    // Entry storage needs no reset; the pointer alone defines which entries are live.
    always_ff @(posedge i_clk) begin
        if (!i_reset && push) stack_mem[push_idx] <= ret_addr;
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: each cycle drives one instruction/PC pair and
// checks the combinational PC controls plus the registered execute stream.
module tb_control_unit;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   instr = 16'hFFFF;
    logic [AW-1:0] pc = '0;
    logic          fz = 1'b0, fc = 1'b0, rdy = 1'b0;
    logic          pc_inc, pc_load, mem_req, exec_valid, halted, stack_error;
    logic [AW-1:0] pc_addr;
    logic [15:0]   exec_instr;
    logic [1:0]    dbg_state;
    logic [2:0]    dbg_sp;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];

    control_unit #(.ADDR_WIDTH(AW), .STACK_DEPTH(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_instruction(instr), .i_pc(pc),
        .i_flag_zero(fz), .i_flag_carry(fc), .i_mem_ready(rdy),
        .o_pc_inc(pc_inc), .o_pc_load(pc_load), .o_pc_addr(pc_addr),
        .o_mem_req(mem_req), .o_exec_valid(exec_valid), .o_exec_instr(exec_instr),
        .o_halted(halted), .o_stack_error(stack_error),
        .o_dbg_state(dbg_state), .o_dbg_sp(dbg_sp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive one cycle's inputs mid-cycle; outputs are sampled right after.
    task automatic cyc(input logic r, input logic [15:0] i, input logic [AW-1:0] p,
                       input logic z = 1'b0, input logic c = 1'b0, input logic m = 1'b0);
        @(negedge clk);
        rst = r; instr = i; pc = p; fz = z; fc = c; rdy = m;
        #1;
    endtask

    task automatic ctl(input string tag, input logic inc, input logic ld, input logic [AW-1:0] a);
        check({tag, ".inc"}, pc_inc, inc);
        check({tag, ".load"}, pc_load, ld);
        check({tag, ".addr"}, pc_addr, a);
    endtask

    task automatic exec_chk(input string tag, input logic want);
        logic [15:0] e;
        check({tag, ".exec_valid"}, exec_valid, want);
        if (want && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, ".exec_instr"}, exec_instr, e);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        // reset state
        cyc(1, 16'hFFFF, 8'h00);
        check("rst.exec_valid", exec_valid, 0);
        check("rst.exec_instr", exec_instr, 16'hFFFF);
        check("rst.halted", halted, 0);
        check("rst.stack_error", stack_error, 0);
        check("rst.sp", dbg_sp, 0);
        check("rst.mem_req", mem_req, 0);

        // boot then straight-line program
        cyc(0, 16'hFFFF, 8'h00); ctl("boot", 0, 1, 8'h00);
        cyc(0, 16'hFFFF, 8'h00); ctl("nop", 1, 0, 8'h00); exec_chk("nop", 0);
        cyc(0, 16'h0123, 8'h01); ctl("i0", 1, 0, 8'h00); exp_q.push_back(16'h0123);
        cyc(0, 16'h0456, 8'h02); ctl("i1", 1, 0, 8'h00); exec_chk("i0", 1); exp_q.push_back(16'h0456);

        // jumps
        cyc(0, 16'h8010, 8'h04); ctl("jmp", 0, 1, 8'h10); exec_chk("i1", 1); exp_q.push_back(16'h8010);
        cyc(0, 16'hFFFF, 8'h10); ctl("jmp_mask", 1, 0, 8'h00); exec_chk("jmp", 1);
        cyc(0, 16'h0AAA, 8'h11); ctl("jmp_tgt", 1, 0, 8'h00); exec_chk("jmp_mask", 0); exp_q.push_back(16'h0AAA);
        cyc(0, 16'h8410, 8'h12, 0); ctl("jz_nt", 1, 0, 8'h00); exec_chk("jmp_tgt", 1); exp_q.push_back(16'h8410);
        cyc(0, 16'h8410, 8'h13, 1); ctl("jz_t", 0, 1, 8'h10); exec_chk("jz_nt", 1); exp_q.push_back(16'h8410);
        cyc(0, 16'hFFFF, 8'h10); ctl("jz_mask", 1, 0, 8'h00); exec_chk("jz_t", 1);
        cyc(0, 16'h8820, 8'h11, 1); ctl("jnz_nt", 1, 0, 8'h00); exp_q.push_back(16'h8820);
        cyc(0, 16'h8C30, 8'h12, 1, 1); ctl("jc_t", 0, 1, 8'h30); exec_chk("jnz_nt", 1); exp_q.push_back(16'h8C30);
        cyc(0, 16'hFFFF, 8'h30); ctl("jc_mask", 1, 0, 8'h00); exec_chk("jc_t", 1);

        // call at address 5 (pc already advanced to 6), return from 0x20
        cyc(0, 16'h9020, 8'h06); ctl("call", 0, 1, 8'h20); check("call.sp_before", dbg_sp, 0);
        exp_q.push_back(16'h9020);
        cyc(0, 16'hFFFF, 8'h20); ctl("call_mask", 1, 0, 8'h00); check("call.sp_after", dbg_sp, 1);
        exec_chk("call", 1);
        cyc(0, 16'hC000, 8'h21); ctl("ret", 0, 1, 8'h06); exp_q.push_back(16'hC000);
        cyc(0, 16'hFFFF, 8'h06); ctl("ret_mask", 1, 0, 8'h00); check("ret.sp_after", dbg_sp, 0);
        exec_chk("ret", 1);

        // load with ready on the fourth wait-cycle sample
        cyc(0, 16'h1111, 8'h07); ctl("pass", 1, 0, 8'h00); exp_q.push_back(16'h1111);
        cyc(0, 16'hA000, 8'h08); ctl("load", 0, 0, 8'h00); check("load.mem_req", mem_req, 1);
        exec_chk("pass", 1); exp_q.push_back(16'hA000);
        cyc(0, 16'h2222, 8'h08); ctl("w1", 0, 0, 8'h00); check("w1.mem_req", mem_req, 1);
        check("w1.state", dbg_state, 2); exec_chk("load", 1);
        cyc(0, 16'h2222, 8'h08); check("w2.mem_req", mem_req, 1); check("w2.inc", pc_inc, 0);
        exec_chk("w2", 0);
        cyc(0, 16'h2222, 8'h08); check("w3.mem_req", mem_req, 1); check("w3.inc", pc_inc, 0);
        cyc(0, 16'h2222, 8'h08, 0, 0, 1); check("w4.mem_req", mem_req, 0); ctl("w4", 0, 0, 8'h00);
        cyc(0, 16'h2222, 8'h08); ctl("resume", 1, 0, 8'h00); exec_chk("w4", 0);
        exp_q.push_back(16'h2222);
        cyc(0, 16'h3333, 8'h09, 0, 0, 1); ctl("stray_rdy", 1, 0, 8'h00); check("stray.mem_req", mem_req, 0);
        exec_chk("resume", 1); exp_q.push_back(16'h3333);

        // nested calls: two returns pop in LIFO order
        cyc(0, 16'h9040, 8'h0B); ctl("c1", 0, 1, 8'h40); exec_chk("stray", 1);
        cyc(0, 16'hFFFF, 8'h40);
        cyc(0, 16'h9050, 8'h42); ctl("c2", 0, 1, 8'h50);
        cyc(0, 16'hFFFF, 8'h50); check("c2.sp", dbg_sp, 2);
        cyc(0, 16'hC000, 8'h51); ctl("r2", 0, 1, 8'h42);
        cyc(0, 16'hFFFF, 8'h42);
        cyc(0, 16'hC000, 8'h43); ctl("r1", 0, 1, 8'h0B);
        cyc(0, 16'hFFFF, 8'h0B); check("r1.sp", dbg_sp, 0);

        // four calls fill the stack, the fifth overflows
        for (int k = 0; k < 4; k++) begin
            cyc(0, 16'h9060 + 16'(k), 8'h0C);
            check($sformatf("fill%0d.load", k), pc_load, 1);
            cyc(0, 16'hFFFF, 8'h61);
        end
        check("full.sp", dbg_sp, 4);
        exp_q.delete();
        cyc(0, 16'h9070, 8'h62); ctl("ovf", 0, 0, 8'h00); exp_q.push_back(16'h9070);
        cyc(0, 16'hFFFF, 8'h62); ctl("ovf_halt", 0, 0, 8'h00);
        check("ovf.halted", halted, 1); check("ovf.err", stack_error, 1); check("ovf.sp", dbg_sp, 4);
        exec_chk("ovf", 1);
        cyc(0, 16'h8010, 8'h62); ctl("halt_jmp", 0, 0, 8'h00); check("halt.err_sticky", stack_error, 1);

        // reset, then return on an empty stack
        cyc(1, 16'hFFFF, 8'h00);
        cyc(0, 16'hFFFF, 8'h00); check("rst2.err", stack_error, 0); check("rst2.halted", halted, 0);
        ctl("boot2", 0, 1, 8'h00);
        cyc(0, 16'hFFFF, 8'h00);
        cyc(0, 16'hC000, 8'h01); ctl("unf", 0, 0, 8'h00);
        cyc(0, 16'hFFFF, 8'h01); check("unf.halted", halted, 1); check("unf.err", stack_error, 1);
        check("unf.sp", dbg_sp, 0);

        // reset during a memory wait
        cyc(1, 16'hFFFF, 8'h00);
        cyc(0, 16'hFFFF, 8'h00);
        cyc(0, 16'hFFFF, 8'h00);
        cyc(0, 16'hB005, 8'h01); check("store.mem_req", mem_req, 1);
        cyc(0, 16'hFFFF, 8'h01); check("sw.mem_req", mem_req, 1);
        cyc(1, 16'hFFFF, 8'h01); check("rst_wait.mem_req", mem_req, 0);
        cyc(0, 16'hFFFF, 8'h01); check("rst_wait.mem_req2", mem_req, 0); ctl("boot3", 0, 1, 8'h00);
        check("rst_wait.exec_valid", exec_valid, 0);

        // halt instruction
        cyc(0, 16'hFFFF, 8'h00); ctl("pre_halt", 1, 0, 8'h00);
        cyc(0, 16'hF000, 8'h01); ctl("halt", 0, 0, 8'h00); check("halt.mem_req", mem_req, 0);
        exp_q.push_back(16'hF000);
        cyc(0, 16'hFFFF, 8'h01); ctl("halted", 0, 0, 8'h00); check("halted.flag", halted, 1);
        check("halted.err", stack_error, 0); exec_chk("halt", 1);
        cyc(0, 16'hFFFF, 8'h01); ctl("halted2", 0, 0, 8'h00); exec_chk("halted2", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Sequencing stage directly downstream of the program counter and instruction ROM. Each cycle it consumes the 16-bit instruction the program counter presents and decides whether to advance the program counter, load it with a jump/call/return target, or hold it during a data-memory access. It owns a small return-address stack and the halt state. It hands each accepted non-NOP instruction, registered, to the execute stage.

## Interface
- ADDR_WIDTH, 8, instruction address width; matches the program counter.
- STACK_DEPTH, 4, return-stack entries; power of two, 2..16.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_instruction  in  16  instruction from the program counter; 16'hFFFF is NOP.
- i_pc  in  ADDR_WIDTH  current program counter address register.
- i_flag_zero  in  1  ALU zero flag, valid every cycle.
- i_flag_carry  in  1  ALU carry flag, valid every cycle.
- i_mem_ready  in  1  data memory completion strobe.
- o_pc_inc  out  1  advance program counter (combinational).
- o_pc_load  out  1  load program counter (combinational; has priority in the PC).
- o_pc_addr  out  ADDR_WIDTH  load target (combinational; 0 when o_pc_load=0).
- o_mem_req  out  1  data memory request, held high until i_mem_ready.
- o_exec_valid  out  1  registered; o_exec_instr is valid this cycle.
- o_exec_instr  out  16  registered copy of the accepted instruction.
- o_halted  out  1  high in HALT.
- o_stack_error  out  1  sticky over/underflow flag; cleared only by reset.

## Operation
- Decode: opcode = i_instruction[15:12]; cond = [11:10]; target = [ADDR_WIDTH-1:0].
- 16'hFFFF is NOP. 16'hF000 is HALT. Any other 0xF opcode is NOP.
- 0x8 JMP: cond 00 always; 01 if zero; 10 if not zero; 11 if carry.
- 0x9 CALL: push the return address, then load the target.
- 0xC RET: pop the stack into o_pc_addr.
- 0xA LOAD and 0xB STORE: memory operations.
- All other opcodes: pass-through; they advance the PC.
- Fetch address tracking: `prev_adv` is a register holding o_pc_inc & ~o_pc_load from the previous cycle.
  - fetch_addr = prev_adv ? i_pc-1 : i_pc.
  - CALL return address = fetch_addr+1, modulo 2^ADDR_WIDTH.
- States:
  - BOOT: o_pc_load=1, o_pc_addr=0, then RUN.
  - RUN: decode i_instruction.
    - NOP or not-taken JMP: o_pc_inc=1.
    - Taken JMP/CALL/RET: o_pc_load=1, o_pc_inc=0.
    - LOAD/STORE: o_pc_inc=0, o_mem_req=1, then MEM_WAIT.
    - HALT: then HALT.
  - MEM_WAIT: o_mem_req=1 and o_pc_inc=0, with i_instruction ignored.
    - On i_mem_ready: o_mem_req drops in that same cycle, and the next state is RUN.
    - The PC is not advanced. The next RUN cycle consumes the instruction then presented, which is already the following instruction.
  - HALT: all PC controls 0, o_halted=1; leaves only on reset.
- Exec output: every RUN cycle with a non-NOP instruction sets o_exec_valid=1 and o_exec_instr=instruction on the next edge. All other cycles set o_exec_valid=0.
- Stack: the pointer counts 0..STACK_DEPTH.
  - CALL when full, or RET when empty: no push/pop, no load; o_stack_error=1, enter HALT.
- Reset, from any state including MEM_WAIT:
  - Next state BOOT; stack pointer 0; prev_adv=0.
  - o_exec_valid=0, o_exec_instr=16'hFFFF, o_stack_error=0, o_halted=0.
  - o_mem_req drops immediately.

## Timing
- Zero-cycle decode: PC controls are combinational from i_instruction and state.
- Branch cost: taken JMP/CALL/RET at cycle t gives the PC's masked NOP at t+1 and the target instruction at t+2. There is no delay slot.
- LOAD/STORE with i_mem_ready at cycle t+k: MEM_WAIT spans t+1..t+k, and the next instruction is consumed at t+k+1. If ready arrives the first MEM_WAIT cycle, the stall is 1 cycle.
- o_exec_* lag acceptance by exactly 1 cycle.
- i_mem_ready outside MEM_WAIT is ignored.

## Test plan
- Reset, then release: cycle 1 gives o_pc_load=1, o_pc_addr=0.
  - Program 0x0123, 0x0456 at addresses 0, 1.
  - o_exec_instr must be 0x0123 then 0x0456, each with o_exec_valid=1.
  - The masked 0xFFFF after load must produce no exec.
- JMP 0x8010 at addr 3: o_pc_load=1, o_pc_addr=0x10; the instruction at 0x10 executes 2 cycles later. With i_flag_zero=0, 0x8410 must instead give o_pc_inc=1.
- CALL 0x9020 at addr 5, then RET 0xC000 at 0x20: o_pc_addr=0x20, then o_pc_addr=6, and the stack pointer returns to 0.
- LOAD 0xA000 with i_mem_ready delayed 3 cycles: o_mem_req is high for 4 cycles; o_pc_inc is 0 throughout; execution resumes at the next address without a skip.
- Five nested CALLs with STACK_DEPTH=4: the fifth gives o_stack_error=1 and o_halted=1 with no o_pc_load. Separately, RET on an empty stack gives the same.
- Assert i_reset during MEM_WAIT: o_mem_req=0 the next cycle, then BOOT load to address 0. 0xF000 must halt with all PC controls 0.
